boot_serial_loader: RTL
=======================

// Module: boot_serial_loader
// PURPOSE
//  Front-end of the FPGA bootloader: receives the program image from the host over a 2-wire link
//  (strobe + data), assembles 32-bit words MSB-first and issues one write per word to the
//  instruction ROM. Sits between the board pins and the ROM write port; written words are
//  consumed only while the CPU is held in reset.
// PARAMETERS
//  WORD_BITS       32     bits per assembled word
//  ADDR_BITS       12     ROM address width; image capacity 2**ADDR_BITS words
//  TIMEOUT_CYCLES  50000  idle clk cycles mid-word before the partial word is discarded
// PORTS
//  clk          in   1          system clock; all logic on rising edge
//  reset        in   1          synchronous, active-high
//  enable       in   1          load mode (CPU held in reset); 0 = link ignored
//  strobe_pin   in   1          async host bit strobe; data is sampled on its rising edge
//  data_pin     in   1          async host serial data
//  word_valid   out  1          1-cycle write strobe to ROM
//  word_out     out  WORD_BITS  assembled word; valid while word_valid=1, held otherwise
//  word_addr    out  ADDR_BITS  ROM address of word_out
//  ready        out  1          in LOAD with no partial word (bit count 0)
//  full         out  1          sticky: 2**ADDR_BITS words written, further bits ignored
//  timeout_err  out  1          sticky: a partial word was discarded by timeout
// BEHAVIOUR
//  - Reset: all outputs 0; word_addr 0; bit count 0; sync flops 0; state IDLE.
//  - strobe_pin and data_pin each pass a 2-flop synchronizer. An edge is sync_strobe=1 with
//    previous sync_strobe=0. The bit is sync_data from the same cycle. Pin-to-capture latency
//    is 3 clk cycles. The host must hold data stable for >=4 clk cycles around each strobe rise
//    and keep strobe high/low >=3 cycles each.
//  - FSM:
//    IDLE: entered on reset or enable=0; bit count cleared; edges ignored.
//      On enable 0->1 (seen in IDLE): word_addr<=0, full<=0, timeout_err<=0, go to LOAD.
//    LOAD: each edge does shreg<={shreg[WORD_BITS-2:0],bit} and bit count +1.
//      On the edge that captures bit WORD_BITS: word_out<=assembled word, bit count<=0.
//      word_valid=1 on the next cycle only, with word_addr = address of that word.
//      word_addr increments the cycle after word_valid.
//      If that word was at address 2**ADDR_BITS-1: set full, word_addr wraps to 0, go to FULL.
//    FULL: edges ignored; no word_valid; stays until enable=0 or reset.
//  - enable 1->0 in any state: go to IDLE the next cycle. Any partial word is discarded (no
//    word_valid). word_addr, full and timeout_err are held for inspection.
//  - Timeout: in LOAD with bit count != 0, a counter runs and is cleared on every edge. When it
//    reaches TIMEOUT_CYCLES: bit count<=0, timeout_err<=1, stay in LOAD, word_addr unchanged.
//    Counter idle (0) when bit count=0.
//  - Simultaneous events: an edge in the same cycle enable falls is ignored. Reset overrides all.
//    Reset mid-word discards the partial word.
//  - ready = (state==LOAD) && (bit count==0) && !word_valid.
//  - No backpressure: ROM accepts a write every cycle; word_valid never repeats for one word.
// TESTING
//  1 reset, enable=1, send 0xDEADBEEF MSB-first -> one word_valid pulse, word_out=0xDEADBEEF,
//    word_addr=0; ready=1 afterwards.
//  2 send 3 words 0x00000001,0x80000000,0xFFFFFFFF -> word_valid x3 at addr 0,1,2 in order;
//    no extra pulses.
//  3 send 10 bits, idle TIMEOUT_CYCLES+5 -> timeout_err=1, no word_valid. Then send 0x12345678
//    -> written at addr 0 intact.
//  4 send 20 bits, drop enable, re-raise, send 0xCAFEF00D -> no pulse for the partial word;
//    0xCAFEF00D at addr 0.
//  5 ADDR_BITS=2: send 5 words -> 4 pulses at addr 0..3; full=1; 5th word produces no pulse.
//  6 assert reset mid-word and mid-FULL -> all outputs 0, state IDLE, next load starts at addr 0.

Source files
------------

// File: rtl/boot_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_serial_loader
// Summary  : Bootloader front-end. It receives the program image over a
//            strobe/data link, assembles it MSB-first into words and issues
//            one instruction-ROM write for each word.
// Revision : 1.0
// ============================================================================
module boot_serial_loader #(
    parameter int WORD_BITS      = 32,
    parameter int ADDR_BITS      = 12,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 strobe_pin,
    input  logic                 data_pin,
    output logic                 word_valid,
    output logic [WORD_BITS-1:0] word_out,
    output logic [ADDR_BITS-1:0] word_addr,
    output logic                 ready,
    output logic                 full,
    output logic                 timeout_err
);

    localparam int BCNT_W = $clog2(WORD_BITS) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_FULL = 2'd2;

    localparam logic [BCNT_W-1:0]    c_BCNT_LAST = BCNT_W'(WORD_BITS - 1);
    localparam logic [TMO_W-1:0]     c_TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] c_ADDR_ONE  = ADDR_BITS'(1);

    logic                 strb_s1_q, strb_s2_q, strb_prev_q;
    logic                 data_s1_q, data_s2_q;
    logic                 en_prev_q;
    logic [1:0]           state_q, state_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [WORD_BITS-2:0] shreg_q, shreg_d;
    logic [WORD_BITS-1:0] word_out_q, word_out_d;
    logic                 word_valid_q, word_valid_d;
    logic [ADDR_BITS-1:0] word_addr_q, word_addr_d;
    logic                 full_q, full_d;
    logic                 tmo_err_q, tmo_err_d;

    logic w_edge;
    logic w_addr_last;

    assign w_edge      = strb_s2_q & ~strb_prev_q;
    assign w_addr_last = &word_addr_q;

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        tmo_d        = tmo_q;
        shreg_d      = shreg_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        word_addr_d  = word_addr_q;
        full_d       = full_q;
        tmo_err_d    = tmo_err_q;

        // The address advances in the cycle after the write strobe.
        if (word_valid_q) begin
            word_addr_d = word_addr_q + c_ADDR_ONE;
            if (w_addr_last) begin
                full_d = 1'b1;
            end
        end

        case (state_q)
            c_ST_IDLE: begin
                bcnt_d = '0;
                tmo_d  = '0;
                if (enable && !en_prev_q) begin
                    word_addr_d = '0;
                    full_d      = 1'b0;
                    tmo_err_d   = 1'b0;
                    state_d     = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (!enable) begin
                    state_d = c_ST_IDLE;
                    bcnt_d  = '0;
                    tmo_d   = '0;
                end else if (word_valid_q && w_addr_last) begin
                    state_d = c_ST_FULL;
                    bcnt_d  = '0;
                    tmo_d   = '0;
                end else if (w_edge) begin
                    tmo_d = '0;
                    if (bcnt_q == c_BCNT_LAST) begin
                        word_out_d   = {shreg_q, data_s2_q};
                        word_valid_d = 1'b1;
                        bcnt_d       = '0;
                    end else begin
                        shreg_d = {shreg_q[WORD_BITS-3:0], data_s2_q};
                        bcnt_d  = bcnt_q + BCNT_W'(1);
                    end
                end else if (bcnt_q != '0) begin
                    // A stalled host loses its partial word but the session continues.
                    if (tmo_q == c_TMO_LAST) begin
                        bcnt_d    = '0;
                        tmo_d     = '0;
                        tmo_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            c_ST_FULL: begin
                bcnt_d = '0;
                tmo_d  = '0;
                if (!enable) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                bcnt_d  = '0;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_s1_q    <= 1'b0;
            strb_s2_q    <= 1'b0;
            strb_prev_q  <= 1'b0;
            data_s1_q    <= 1'b0;
            data_s2_q    <= 1'b0;
            en_prev_q    <= 1'b0;
            state_q      <= c_ST_IDLE;
            bcnt_q       <= '0;
            tmo_q        <= '0;
            shreg_q      <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_addr_q  <= '0;
            full_q       <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            strb_s1_q    <= strobe_pin;
            strb_s2_q    <= strb_s1_q;
            strb_prev_q  <= strb_s2_q;
            data_s1_q    <= data_pin;
            data_s2_q    <= data_s1_q;
            en_prev_q    <= enable;
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            tmo_q        <= tmo_d;
            shreg_q      <= shreg_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_addr_q  <= word_addr_d;
            full_q       <= full_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign word_valid  = word_valid_q;
    assign word_out    = word_out_q;
    assign word_addr   = word_addr_q;
    assign full        = full_q;
    assign timeout_err = tmo_err_q;
    assign ready       = (state_q == c_ST_LOAD) && (bcnt_q == '0) && !word_valid_q;

endmodule
`default_nettype wire
